// File: rtl/rv3n_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv3n_fetch_ctrl_pkg
// Shared constants for the rv3n instruction-fetch sequencer: datapath widths,
// the RISC-V opcodes the taken-hint predictor recognises, and the fetch FSM
// state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package rv3n_fetch_ctrl_pkg;

  localparam int RV3N_XLEN = 32;  // data/address width
  localparam int RV3N_INUM = 2;   // 32-bit words per fetch block
  localparam int RV3N_HLEN = 16;  // halfword width

  localparam logic [6:0] RV3N_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] RV3N_OPC_JAL    = 7'b1101111;

  // RUN : no request pending on imem (or the pending one was just granted).
  // HOLD: imem_req is high and waiting for imem_gnt; address must not move.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/rv3n_fetch_predict.sv
// -----------------------------------------------------------------------------
// rv3n_fetch_predict
// Combinational static taken-hint for one fetch block. For every halfword h the
// 32-bit word starting at h is decoded: a backward conditional branch
// (BRANCH opcode with imm[12] = 1) or a JAL marks the halfword as taken. The
// last halfword cannot hold a full 32-bit word inside the block, so its hint
// is always 0.
// Only elaborated when RV3N_FETCH_PREDICT_EN is defined.
// Ports:
//   block_i   [INUM*XLEN-1:0]  fetch block data
//   predict_o [INUM*2-1:0]     per-halfword taken hint
// -----------------------------------------------------------------------------
module rv3n_fetch_predict
  import rv3n_fetch_ctrl_pkg::*;
#(
  parameter int XLEN = RV3N_XLEN,
  parameter int INUM = RV3N_INUM
) (
  input  logic [INUM*XLEN-1:0] block_i,
  output logic [INUM*2-1:0]    predict_o
);

  localparam int NHW = INUM * 2;

  logic [31:0] word;

  always_comb begin
    predict_o = '0;
    word      = '0;
    for (int h = 0; h < NHW - 1; h++) begin
      word         = block_i[h*RV3N_HLEN +: 32];
      predict_o[h] = ((word[6:0] == RV3N_OPC_BRANCH) && word[31]) ||
                     (word[6:0] == RV3N_OPC_JAL);
    end
  end

endmodule

// File: rtl/rv3n_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// rv3n_fetch_ctrl
// Instruction-fetch sequencer between the imem port and the decode buffer.
// Owns the fetch PC, issues block-aligned requests while decode has room,
// counts outstanding (granted, unanswered) requests, drops responses made
// stale by a redirect and forwards surviving responses to decode one cycle
// after imem_rvalid.
//
// Optional feature: define RV3N_FETCH_PREDICT_EN to elaborate the static
// taken-hint predictor (rv3n_fetch_predict); otherwise if2dc_predict is 0.
//
// Ports:
//   clk              clock
//   rst              asynchronous reset, active low
//   dc2if_new_valid  redirect request
//   dc2if_new_pc     redirect target (aligned down to the block here)
//   dc2if_continue   decode buffer can absorb one more block
//   imem_req/addr    registered fetch request / block-aligned address
//   imem_gnt         request accepted this cycle
//   imem_rvalid/rdata/err  in-order response
//   if2dc_valid/rdata/err/predict  registered block to decode
//   fetch_proto_err  sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module rv3n_fetch_ctrl
  import rv3n_fetch_ctrl_pkg::*;
#(
  parameter int              XLEN     = RV3N_XLEN,
  parameter int              INUM     = RV3N_INUM,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dc2if_new_valid,
  input  logic [XLEN-1:0]      dc2if_new_pc,
  input  logic                 dc2if_continue,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [INUM*XLEN-1:0] imem_rdata,
  input  logic                 imem_err,
  output logic                 if2dc_valid,
  output logic [INUM*XLEN-1:0] if2dc_rdata,
  output logic                 if2dc_err,
  output logic [INUM*2-1:0]    if2dc_predict,
  output logic                 fetch_proto_err
);

  localparam int              BW          = INUM * XLEN;
  localparam int              CW          = $clog2(MAX_OUT + 2);
  localparam logic [XLEN-1:0] BLK_BYTES   = XLEN'(INUM * 4);
  localparam logic [XLEN-1:0] BLK_MASK    = ~(BLK_BYTES - XLEN'(1));
  localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & BLK_MASK;
  localparam logic [CW-1:0]   MAX_C       = CW'(MAX_OUT);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;     // address of the request on imem
  logic [XLEN-1:0]   pc_q, pc_d;         // next block address to issue
  logic [CW-1:0]     out_q, out_d;       // granted, unanswered requests
  logic [CW-1:0]     drop_q, drop_d;     // responses still to discard
  logic              stale_q, stale_d;   // pending HOLD request predates a redirect
  logic              perr_q, perr_d;
  logic              vld_q, vld_d;
  logic [BW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [INUM*2-1:0] pred_q, pred_d;

  logic              grant;
  logic              resp_ok;
  logic              resp_drop;
  logic              fwd;
  logic              can_issue;
  logic [XLEN-1:0]   new_pc_al;
  logic [INUM*2-1:0] pred_c;

`ifdef RV3N_FETCH_PREDICT_EN
  rv3n_fetch_predict #(
    .XLEN (XLEN),
    .INUM (INUM)
  ) u_predict (
    .block_i   (imem_rdata),
    .predict_o (pred_c)
  );
`else
  assign pred_c = '0;
`endif

  always_comb begin
    grant     = (state_q == ST_HOLD) && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_ok   = imem_rvalid && (out_q != '0);
    resp_drop = resp_ok && (drop_q != '0);
    fwd       = resp_ok && !resp_drop && !dc2if_new_valid;
    new_pc_al = dc2if_new_pc & BLK_MASK;
    out_d     = out_q + CW'(grant) - CW'(resp_ok);
    // Room is judged on the count after this cycle's grant and response.
    can_issue = ((state_q == ST_RUN) || grant) && dc2if_continue && (out_d < MAX_C);

    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    drop_d  = drop_q - CW'(resp_drop);
    stale_d = stale_q;

    if (grant) begin
      state_d = ST_RUN;
      if (stale_q) begin
        drop_d = drop_d + CW'(1);
      end
      stale_d = 1'b0;
    end

    if (dc2if_new_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      drop_d = out_d;
      pc_d   = new_pc_al;
      if ((state_q == ST_HOLD) && !grant) begin
        // Request cannot be withdrawn; count it as stale once granted.
        stale_d = 1'b1;
      end else if (can_issue) begin
        state_d = ST_HOLD;
        addr_d  = new_pc_al;
        pc_d    = new_pc_al + BLK_BYTES;
      end
    end else if (can_issue) begin
      state_d = ST_HOLD;
      addr_d  = pc_q;
      pc_d    = pc_q + BLK_BYTES;
    end

    perr_d  = perr_q | (imem_rvalid && (out_q == '0));
    vld_d   = fwd;
    rdata_d = fwd ? imem_rdata : rdata_q;
    err_d   = fwd ? imem_err   : err_q;
    pred_d  = fwd ? pred_c     : pred_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      addr_q  <= RESET_PC_AL;
      pc_q    <= RESET_PC_AL;
      out_q   <= '0;
      drop_q  <= '0;
      stale_q <= 1'b0;
      perr_q  <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      pred_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      stale_q <= stale_d;
      perr_q  <= perr_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      pred_q  <= pred_d;
    end
  end

  assign imem_req        = (state_q == ST_HOLD);
  assign imem_addr       = addr_q;
  assign if2dc_valid     = vld_q;
  assign if2dc_rdata     = rdata_q;
  assign if2dc_err       = err_q;
  assign if2dc_predict   = pred_q;
  assign fetch_proto_err = perr_q;

endmodule
